// File: rtl/kbd_move_ctrl.sv
// rtl/kbd_move_ctrl.sv - PS/2 arrow/WASD key tracker with per-frame direction strobe
//
// Purpose:
//   Parses PS/2 set-2 scan codes (make, F0 break, E0 extended prefix) into
//   four held-key flags, merges them with board buttons, and once per VGA
//   frame (vsync falling edge) emits a one-clock strobe with the resolved
//   direction. Opposing requests on the same axis cancel each other.
//
// Ports:
//   in_clock       board clock, all state updates on its rising edge
//   in_reset       synchronous active-high reset
//   in_code        scan-code byte, qualified by in_code_valid
//   in_code_valid  one-clock pulse marking a new in_code
//   in_vsync       VGA vsync level (active-low), synchronous to in_clock
//   in_btn_*       debounced board buttons, active-high levels
//   out_held       held-key flags {up,down,left,right}
//   out_move_stb   one-clock pulse per frame
//   out_dir        resolved direction {up,down,left,right}, updated with out_move_stb

module kbd_move_ctrl #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       in_clock,
    input  logic       in_reset,
    input  logic [7:0] in_code,
    input  logic       in_code_valid,
    input  logic       in_vsync,
    input  logic       in_btn_up,
    input  logic       in_btn_down,
    input  logic       in_btn_left,
    input  logic       in_btn_right,
    output logic [3:0] out_held,
    output logic       out_move_stb,
    output logic [3:0] out_dir
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BRK     = 2'd1;
    localparam logic [1:0] S_EXT     = 2'd2;
    localparam logic [1:0] S_EXT_BRK = 2'd3;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [15:0] idle_cnt;
    logic        vsync_prev;
    logic        vsync_fall;
    logic [3:0]  plain_bit;
    logic [3:0]  ext_bit;
    logic [3:0]  key_bit;
    logic        is_break;
    logic [3:0]  dir_req;
    logic [3:0]  dir_resolved;

    // Key decode: one-hot position in {up,down,left,right}, zero when unmapped.
    always_comb begin
        plain_bit = 4'b0000;
        case (in_code)
            8'h1D:   plain_bit = 4'b1000;
            8'h1B:   plain_bit = 4'b0100;
            8'h1C:   plain_bit = 4'b0010;
            8'h23:   plain_bit = 4'b0001;
            default: plain_bit = 4'b0000;
        endcase
    end

    always_comb begin
        ext_bit = 4'b0000;
        case (in_code)
            8'h75:   ext_bit = 4'b1000;
            8'h72:   ext_bit = 4'b0100;
            8'h6B:   ext_bit = 4'b0010;
            8'h74:   ext_bit = 4'b0001;
            default: ext_bit = 4'b0000;
        endcase
    end

    // After an E0 prefix only the extended map applies, so E0 1D decodes to nothing.
    always_comb begin
        key_bit  = (state == S_EXT || state == S_EXT_BRK) ? ext_bit : plain_bit;
        is_break = (state == S_BRK || state == S_EXT_BRK);
    end

    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE: begin
                if (in_code == 8'hF0)      state_next = S_BRK;
                else if (in_code == 8'hE0) state_next = S_EXT;
                else                       state_next = S_IDLE;
            end
            S_EXT:   state_next = (in_code == 8'hF0) ? S_EXT_BRK : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Axis cancellation: pressing both opposing directions means "don't move".
    always_comb begin
        dir_req      = out_held | {in_btn_up, in_btn_down, in_btn_left, in_btn_right};
        dir_resolved = dir_req;
        if (dir_req[3] && dir_req[2]) dir_resolved[3:2] = 2'b00;
        if (dir_req[1] && dir_req[0]) dir_resolved[1:0] = 2'b00;
    end

    // vsync_prev resets to 0 so a low vsync right after reset is not an edge.
    assign vsync_fall = vsync_prev && !in_vsync;

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state        <= S_IDLE;
            idle_cnt     <= 16'd0;
            out_held     <= 4'b0000;
            out_dir      <= 4'b0000;
            out_move_stb <= 1'b0;
            vsync_prev   <= 1'b0;
        end else begin
            vsync_prev   <= in_vsync;
            out_move_stb <= vsync_fall;
            // Uses the held flags from before any byte arriving this same cycle.
            if (vsync_fall) out_dir <= dir_resolved;

            if (in_code_valid) begin
                state    <= state_next;
                idle_cnt <= 16'd0;
                if (is_break) out_held <= out_held & ~key_bit;
                else          out_held <= out_held | key_bit;
            end else if (state == S_IDLE) begin
                idle_cnt <= 16'd0;
            end else if (idle_cnt == TIMEOUT_LAST) begin
                // Abandon a stale prefix so the next byte is parsed fresh.
                state    <= S_IDLE;
                idle_cnt <= 16'd0;
            end else begin
                idle_cnt <= idle_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_kbd_move_ctrl.sv
// tb/tb_kbd_move_ctrl.sv - directed table-driven bench for kbd_move_ctrl

module tb_kbd_move_ctrl;

    localparam int TMO = 20;

    logic       in_clock;
    logic       in_reset;
    logic [7:0] in_code;
    logic       in_code_valid;
    logic       in_vsync;
    logic       in_btn_up;
    logic       in_btn_down;
    logic       in_btn_left;
    logic       in_btn_right;
    logic [3:0] out_held;
    logic       out_move_stb;
    logic [3:0] out_dir;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [7:0] code;
        logic       valid;
        logic       vsync;
        logic [3:0] btn;
        logic [3:0] held;
        logic       stb;
        logic [3:0] dir;
    } vec_t;

    vec_t vecs[$];

    kbd_move_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .in_clock      (in_clock),
        .in_reset      (in_reset),
        .in_code       (in_code),
        .in_code_valid (in_code_valid),
        .in_vsync      (in_vsync),
        .in_btn_up     (in_btn_up),
        .in_btn_down   (in_btn_down),
        .in_btn_left   (in_btn_left),
        .in_btn_right  (in_btn_right),
        .out_held      (out_held),
        .out_move_stb  (out_move_stb),
        .out_dir       (out_dir)
    );

    initial begin
        in_clock = 1'b0;
        forever #5 in_clock = ~in_clock;
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] code, input logic valid, input logic vsync,
                       input logic [3:0] btn, input logic [3:0] held, input logic stb,
                       input logic [3:0] dir);
        vec_t v;
        v.code = code; v.valid = valid; v.vsync = vsync; v.btn = btn;
        v.held = held; v.stb = stb; v.dir = dir;
        vecs.push_back(v);
    endtask

    // Called at a negedge; returns at the negedge after the byte was sampled.
    task automatic send_byte(input logic [7:0] b);
        in_code       = b;
        in_code_valid = 1'b1;
        @(negedge in_clock);
        in_code_valid = 1'b0;
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        in_reset      = 1'b1;
        in_code       = 8'h00;
        in_code_valid = 1'b0;
        in_vsync      = 1'b0;
        in_btn_up     = 1'b0;
        in_btn_down   = 1'b0;
        in_btn_left   = 1'b0;
        in_btn_right  = 1'b0;

        //   code   v  vs  btn      held     stb  dir
        add(8'h1D, 1, 1, 4'b0000, 4'b1000, 0, 4'b0000);
        add(8'hF0, 1, 1, 4'b0000, 4'b1000, 0, 4'b0000);
        add(8'h1D, 1, 1, 4'b0000, 4'b0000, 0, 4'b0000);
        add(8'hE0, 1, 1, 4'b0000, 4'b0000, 0, 4'b0000);
        add(8'h6B, 1, 1, 4'b0000, 4'b0010, 0, 4'b0000);
        add(8'h00, 0, 0, 4'b0000, 4'b0010, 1, 4'b0010);
        add(8'h00, 0, 0, 4'b0000, 4'b0010, 0, 4'b0010);
        add(8'hE0, 1, 1, 4'b0000, 4'b0010, 0, 4'b0010);
        add(8'hF0, 1, 1, 4'b0000, 4'b0010, 0, 4'b0010);
        add(8'h6B, 1, 1, 4'b0000, 4'b0000, 0, 4'b0010);
        add(8'h1D, 1, 1, 4'b0000, 4'b1000, 0, 4'b0010);
        add(8'h00, 0, 0, 4'b0100, 4'b1000, 1, 4'b0000);
        add(8'h00, 0, 0, 4'b0100, 4'b1000, 0, 4'b0000);
        add(8'h1D, 1, 1, 4'b0000, 4'b1000, 0, 4'b0000);
        add(8'hE0, 1, 1, 4'b0000, 4'b1000, 0, 4'b0000);
        add(8'h1D, 1, 1, 4'b0000, 4'b1000, 0, 4'b0000);
        add(8'h23, 1, 1, 4'b0000, 4'b1001, 0, 4'b0000);
        add(8'h1C, 1, 1, 4'b0000, 4'b1011, 0, 4'b0000);
        add(8'h00, 0, 0, 4'b0000, 4'b1011, 1, 4'b1000);
        add(8'h12, 1, 1, 4'b0000, 4'b1011, 0, 4'b1000);
        add(8'hF0, 1, 1, 4'b0000, 4'b1011, 0, 4'b1000);
        add(8'h12, 1, 1, 4'b0000, 4'b1011, 0, 4'b1000);
        add(8'hE0, 1, 1, 4'b0000, 4'b1011, 0, 4'b1000);
        add(8'h75, 1, 1, 4'b0000, 4'b1011, 0, 4'b1000);
        add(8'hE0, 1, 1, 4'b0000, 4'b1011, 0, 4'b1000);
        add(8'hF0, 1, 1, 4'b0000, 4'b1011, 0, 4'b1000);
        add(8'h75, 1, 1, 4'b0000, 4'b0011, 0, 4'b1000);
        add(8'hF0, 1, 1, 4'b0000, 4'b0011, 0, 4'b1000);
        add(8'h1C, 1, 1, 4'b0000, 4'b0001, 0, 4'b1000);
        add(8'hF0, 1, 1, 4'b0000, 4'b0001, 0, 4'b1000);
        add(8'h23, 1, 1, 4'b0000, 4'b0000, 0, 4'b1000);
        add(8'h23, 1, 0, 4'b0000, 4'b0001, 1, 4'b0000);
        add(8'h00, 0, 0, 4'b0000, 4'b0001, 0, 4'b0000);
        add(8'h00, 0, 1, 4'b0000, 4'b0001, 0, 4'b0000);
        add(8'h00, 0, 0, 4'b0000, 4'b0001, 1, 4'b0001);
        add(8'h00, 0, 1, 4'b1000, 4'b0001, 0, 4'b0001);
        add(8'h00, 0, 0, 4'b1000, 4'b0001, 1, 4'b1001);
        add(8'h00, 0, 1, 4'b0000, 4'b0001, 0, 4'b1001);

        // Reset state, held with vsync low
        repeat (3) @(negedge in_clock);
        check("reset_held", out_held, 4'b0000);
        check("reset_stb", {3'b000, out_move_stb}, 4'b0000);
        check("reset_dir", out_dir, 4'b0000);

        // Release with vsync already low: no strobe in the first clocks
        in_reset = 1'b0;
        @(negedge in_clock);
        check("post_reset_stb0", {3'b000, out_move_stb}, 4'b0000);
        @(negedge in_clock);
        check("vsync_low_stb", {3'b000, out_move_stb}, 4'b0000);
        in_vsync = 1'b1;
        @(negedge in_clock);
        check("vsync_rise_stb", {3'b000, out_move_stb}, 4'b0000);

        foreach (vecs[i]) begin
            in_code       = vecs[i].code;
            in_code_valid = vecs[i].valid;
            in_vsync      = vecs[i].vsync;
            {in_btn_up, in_btn_down, in_btn_left, in_btn_right} = vecs[i].btn;
            @(negedge in_clock);
            in_code_valid = 1'b0;
            check($sformatf("vec%0d_held", i), out_held, vecs[i].held);
            check($sformatf("vec%0d_stb", i), {3'b000, out_move_stb}, {3'b000, vecs[i].stb});
            check($sformatf("vec%0d_dir", i), out_dir, vecs[i].dir);
        end

        // Clear state for the timeout sequences
        in_vsync = 1'b1;
        {in_btn_up, in_btn_down, in_btn_left, in_btn_right} = 4'b0000;
        in_reset = 1'b1;
        @(negedge in_clock);
        in_reset = 1'b0;
        @(negedge in_clock);
        check("reset2_held", out_held, 4'b0000);

        // F0 then TMO idle clocks: prefix abandoned, 23 is a make
        send_byte(8'hF0);
        repeat (TMO) @(negedge in_clock);
        send_byte(8'h23);
        check("timeout_make", out_held, 4'b0001);

        // F0 then TMO-1 idle clocks: prefix still live, 23 is a break
        send_byte(8'hF0);
        repeat (TMO - 1) @(negedge in_clock);
        send_byte(8'h23);
        check("timeout_edge_break", out_held, 4'b0000);

        // E0 timeout: 1D afterwards is a plain make, not ignored
        send_byte(8'hE0);
        repeat (TMO) @(negedge in_clock);
        send_byte(8'h1D);
        check("ext_timeout_make", out_held, 4'b1000);

        // Reset in the middle of E0 F0 discards the prefix
        send_byte(8'hE0);
        send_byte(8'hF0);
        in_reset = 1'b1;
        @(negedge in_clock);
        in_reset = 1'b0;
        check("midseq_reset_held", out_held, 4'b0000);
        send_byte(8'h1C);
        check("after_reset_make", out_held, 4'b0010);
        send_byte(8'h1D);
        check("after_reset_make2", out_held, 4'b1010);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
